// File: rtl/ldpc_3gpp_dec_iter_ctrl.sv
// Iteration scheduler for the LDPC 3GPP decoder check-node datapath: sweeps rows/tiles per
// iteration and decides stop/continue on decfail. Optional macro: LDPC_3GPP_DEC_ITER_EARLY_STOP_EN.
module ldpc_3gpp_dec_iter_ctrl #(
  parameter int pROW_MAX  = 46,
  parameter int pTCNT_MAX = 16,
  parameter int pITER_W   = 8,
  localparam int ROW_W    = $clog2(pROW_MAX),
  localparam int TCNT_W   = $clog2(pTCNT_MAX)
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pITER_W-1:0] iNiter,
  input  logic [ROW_W-1:0]   irow_num,
  input  logic [TCNT_W-1:0]  itcnt_num,
  input  logic               irdy,
  input  logic               idecfail_val,
  input  logic               idecfail,
  output logic               ocnode_start,
  output logic               ocnode_load,
  output logic               oval,
  output logic [3:0]         ostrb,
  output logic [ROW_W-1:0]   orow,
  output logic [TCNT_W-1:0]  otcnt,
  output logic [pITER_W-1:0] oiter,
  output logic               obusy,
  output logic               odone,
  output logic               odecfail,
  output logic [pITER_W-1:0] oused_iter
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [ROW_W-1:0]     row, row_num_r;
  logic [TCNT_W-1:0]    tcnt, tcnt_num_r;
  logic [pITER_W-1:0]   iter, iter_last;
  logic                 beat, last_tile, last_row, first_tile, stop;

  assign beat       = (state == S_RUN) & irdy & iclkena;
  assign first_tile = (tcnt == '0);
  assign last_tile  = (tcnt == tcnt_num_r);
  assign last_row   = (row == row_num_r);

`ifdef LDPC_3GPP_DEC_ITER_EARLY_STOP_EN
  assign stop = (iter == iter_last) | ~idecfail;
`else
  assign stop = (iter == iter_last);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (istart) state_nxt = S_RUN;
      S_RUN:  if (beat && last_tile && last_row) state_nxt = S_WAIT;
      S_WAIT: if (idecfail_val) state_nxt = stop ? S_DONE : S_RUN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       state <= S_IDLE;
    else if (iclkena) state <= state_nxt;
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      row          <= '0;
      tcnt         <= '0;
      iter         <= '0;
      row_num_r    <= '0;
      tcnt_num_r   <= '0;
      iter_last    <= '0;
      ocnode_start <= 1'b0;
      ocnode_load  <= 1'b0;
      odecfail     <= 1'b0;
      oused_iter   <= '0;
    end else if (iclkena) begin
      ocnode_start <= (state == S_IDLE) & istart;
      case (state)
        S_IDLE: if (istart) begin
          row_num_r   <= irow_num;
          tcnt_num_r  <= itcnt_num;
          // a zero iteration limit still runs one iteration
          iter_last   <= (iNiter == '0) ? '0 : iNiter - pITER_W'(1);
          row         <= '0;
          tcnt        <= '0;
          iter        <= '0;
          ocnode_load <= 1'b1;
          odecfail    <= 1'b0;
          oused_iter  <= '0;
        end
        S_RUN: if (irdy) begin
          if (last_tile) begin
            tcnt <= '0;
            row  <= last_row ? '0 : row + ROW_W'(1);
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_WAIT: if (idecfail_val) begin
          ocnode_load <= 1'b0;
          if (stop) begin
            odecfail   <= idecfail;
            oused_iter <= iter + pITER_W'(1);
          end else begin
            iter <= iter + pITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oval  = beat;
  assign ostrb = beat ? {first_tile & (row == '0), first_tile, last_tile, last_tile & last_row}
                      : 4'b0000;
  assign orow  = row;
  assign otcnt = tcnt;
  assign oiter = iter;
  assign obusy = (state != S_IDLE);
  assign odone = (state == S_DONE);

endmodule

// File: tb/tb_ldpc_3gpp_dec_iter_ctrl.sv
// Scoreboard bench for ldpc_3gpp_dec_iter_ctrl: driver queues expected beats and done status,
// a negedge monitor pops and compares whenever oval/odone is presented.
module tb_ldpc_3gpp_dec_iter_ctrl;

  logic       iclk, ireset, iclkena, istart, irdy, idecfail_val, idecfail;
  logic [7:0] iNiter;
  logic [5:0] irow_num;
  logic [3:0] itcnt_num;
  logic       ocnode_start, ocnode_load, oval, obusy, odone, odecfail;
  logic [3:0] ostrb;
  logic [5:0] orow;
  logic [3:0] otcnt;
  logic [7:0] oiter, oused_iter;

  typedef struct packed {
    logic [5:0] row;
    logic [3:0] tcnt;
    logic [7:0] iter;
    logic [3:0] strb;
    logic       load;
  } beat_t;

  typedef struct packed {
    logic       dec;
    logic [7:0] used;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int compared   = 0;
  int mismatched = 0;

  ldpc_3gpp_dec_iter_ctrl #(.pROW_MAX(46), .pTCNT_MAX(16), .pITER_W(8)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart), .iNiter(iNiter),
    .irow_num(irow_num), .itcnt_num(itcnt_num), .irdy(irdy), .idecfail_val(idecfail_val),
    .idecfail(idecfail), .ocnode_start(ocnode_start), .ocnode_load(ocnode_load), .oval(oval),
    .ostrb(ostrb), .orow(orow), .otcnt(otcnt), .oiter(oiter), .obusy(obusy), .odone(odone),
    .odecfail(odecfail), .oused_iter(oused_iter)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event not as expected", name);
  endtask

  always @(negedge iclk) begin
    if (!ireset) begin
      if (oval) begin
        if (beat_q.size() == 0) fail_now("unexpected_beat");
        else check("beat{row,tcnt,iter,strb,load}",
                   {orow, otcnt, oiter, ostrb, ocnode_load}, beat_q.pop_front());
      end
      if (odone) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else check("done{decfail,used_iter}", {odecfail, oused_iter}, done_q.pop_front());
      end
    end
  end

  task automatic push_sweep(input int it, input int rn, input int tn);
    beat_t b;
    for (int r = 0; r <= rn; r++) begin
      for (int t = 0; t <= tn; t++) begin
        b.row  = 6'(r);
        b.tcnt = 4'(t);
        b.iter = 8'(it);
        b.strb = {(t == 0) && (r == 0), t == 0, t == tn, (t == tn) && (r == rn)};
        b.load = (it == 0);
        beat_q.push_back(b);
      end
    end
  endtask

  // returns at the negedge right after the job start edge
  task automatic start_job(input int niter, input int rn, input int tn);
    @(posedge iclk); #1;
    iNiter = 8'(niter); irow_num = 6'(rn); itcnt_num = 4'(tn); istart = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b0;
    @(negedge iclk);
    check("cnode_start_pulse", ocnode_start, 1);
    check("busy_after_start", obusy, 1);
  endtask

  task automatic wait_eof(output bit ok);
    int n = 0;
    while (!(oval === 1'b1 && ostrb[0] === 1'b1) && n < 3000) begin
      @(negedge iclk);
      n++;
    end
    ok = (n < 3000);
    if (!ok) fail_now("eof_timeout");
  endtask

  task automatic run_job(input int niter, input int rn, input int tn, input int zero_at,
                         input bit poke, input bit stall);
    int nmax;
    bit ok, dec, stp, early;
    nmax = (niter == 0) ? 1 : niter;
`ifdef LDPC_3GPP_DEC_ITER_EARLY_STOP_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    push_sweep(0, rn, tn);
    start_job(niter, rn, tn);
    if (poke) begin
      @(posedge iclk); #1;
      istart = 1'b1; idecfail_val = 1'b1; idecfail = 1'b0;
      @(posedge iclk); #1;
      istart = 1'b0; idecfail_val = 1'b0;
      @(negedge iclk);
    end
    if (stall) begin
      for (int s = 0; s < 2; s++) begin
        @(posedge iclk); #1;
        irdy = 1'b0;
        @(negedge iclk);
        check("stall_hold{val,row,tcnt,strb}", {oval, orow, otcnt, ostrb},
              {1'b0, 6'd0, 4'd1, 4'd0});
      end
      @(posedge iclk); #1;
      irdy = 1'b1;
      @(negedge iclk);
    end
    for (int it = 0; it < 300; it++) begin
      wait_eof(ok);
      if (!ok) return;
      dec = (it != zero_at);
      stp = (it == nmax - 1) || (early && !dec);
      if (stp) done_q.push_back({dec, 8'(it + 1)});
      else push_sweep(it + 1, rn, tn);
      @(posedge iclk); #1;
      idecfail_val = 1'b1; idecfail = dec;
      @(posedge iclk); #1;
      idecfail_val = 1'b0; idecfail = 1'b0;
      @(negedge iclk);
      if (stp) begin
        check("odone_pulse", odone, 1);
        @(negedge iclk);
        check("idle_after_done{busy,done}", {obusy, odone}, 0);
        check("held_status{decfail,used}", {odecfail, oused_iter}, {dec, 8'(it + 1)});
        break;
      end
    end
  endtask

  initial begin
    int n;
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; irdy = 1'b1;
    idecfail_val = 1'b0; idecfail = 1'b0;
    iNiter = '0; irow_num = '0; itcnt_num = '0;
    #12;
    check("reset_outputs", {ocnode_start, ocnode_load, oval, ostrb, orow, otcnt, oiter,
                            obusy, odone, odecfail, oused_iter}, 0);
    @(posedge iclk); #1;
    ireset = 1'b0;

    run_job(1, 3, 1, -1, 1'b0, 1'b0);
    run_job(4, 2, 2, -1, 1'b1, 1'b0);
    run_job(10, 1, 1, 2, 1'b0, 1'b0);
    run_job(1, 0, 3, -1, 1'b0, 1'b1);
    run_job(0, 0, 0, -1, 1'b0, 1'b0);

    // reset mid-job at row 2
    push_sweep(0, 3, 0);
    start_job(1, 3, 0);
    n = 0;
    while (!(oval === 1'b1 && orow == 6'd2) && n < 100) begin
      @(negedge iclk);
      n++;
    end
    if (n >= 100) fail_now("row2_timeout");
    @(posedge iclk); #1;
    ireset = 1'b1;
    #1;
    check("midjob_reset_outputs", {ocnode_start, ocnode_load, oval, ostrb, orow, otcnt, oiter,
                                   obusy, odone, odecfail, oused_iter}, 0);
    check("pending_beats_at_reset", beat_q.size(), 1);
    beat_q.delete();
    @(posedge iclk); #1;
    ireset = 1'b0;
    run_job(2, 3, 0, -1, 1'b0, 1'b0);

    repeat (3) @(negedge iclk);
    check("beat_queue_drained", beat_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
